// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: owns the word RAM and serves one
// read/write request at a time, completing each after WAIT_STATES wait cycles.
module mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err
);

  localparam int unsigned    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]     WS_L    = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (WAIT_STATES > 15) begin : g_waitStatesCheck
    $error("mem_responder: WAIT_STATES must be in 0..15");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_depthCheck
    $error("mem_responder: DEPTH exceeds the address space");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_accept;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_inRange;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  assign w_inRange = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx     = r_addr[IDX_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A new request can be taken while idle or in the ack cycle, giving back-to-back service.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:   if (i_req) w_accept = 1'b1;
      S_WAIT:   if (r_cnt <= 4'd1) w_nextState = S_ACCESS;
      S_ACCESS: w_nextState = S_RESP;
      S_RESP: begin
        if (i_req) w_accept = 1'b1;
        else       w_nextState = S_IDLE;
      end
      default:  w_nextState = S_IDLE;
    endcase
    if (w_accept) w_nextState = (WS_L == 4'd0) ? S_ACCESS : S_WAIT;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_busy <= (w_nextState != S_IDLE);
      r_ack  <= (r_state == S_ACCESS);
      if (w_accept) begin
        r_addr  <= i_addr;
        r_we    <= i_we;
        r_wdata <= i_wdata;
        r_cnt   <= WS_L;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        r_err   <= !w_inRange;
        r_rdata <= r_we ? r_wdata : (w_inRange ? r_mem[w_idx] : '0);
      end else if (r_state == S_RESP && !i_req) begin
        r_err <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge i_clk) begin
    if (r_state == S_ACCESS && r_we && w_inRange) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign o_busy  = r_busy;
  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule
